// File: rtl/read_seq_pkg.sv
// ---------------------------------------------------------------------------
// read_seq_pkg
// Shared definitions for the read_sequencer slice: the FSM state encoding
// and default job constants.
// Optional feature macro: SEQ_TIMEOUT_EN (adds the ERROR state).
// ---------------------------------------------------------------------------
package read_seq_pkg;

    localparam int DEF_KERNEL_SIZE    = 9;     // kernel length, 32-bit words
    localparam int DEF_KERNEL_LATENCY = 2;     // extra BRAM read-latency cycles
    localparam int DEF_NUM_IMAGES     = 3;     // images per job
    localparam int DEF_IMAGE_PIXELS   = 784;   // pixel beats per image
    localparam int DEF_TIMEOUT_CYCLES = 4096;  // stalled-stream watchdog limit

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        LOAD_KERNEL  = 3'd1,
        IMAGE_REQ    = 3'd2,
        IMAGE_STREAM = 3'd3,
        DONE         = 3'd4
`ifdef SEQ_TIMEOUT_EN
        ,
        ERROR        = 3'd5
`endif
    } seq_state_t;

endpackage

// File: rtl/seq_watchdog.sv
// ---------------------------------------------------------------------------
// seq_watchdog
// Loadable up-counter with a terminal flag. `load` forces the count to zero;
// otherwise the count advances while `en` is high and parks at LIMIT-1.
// Used by read_sequencer only when SEQ_TIMEOUT_EN is defined.
//
// Ports:
//   clk      in   clock, rising edge
//   reset    in   asynchronous, active-low clear
//   load     in   restart the count at zero
//   en       in   count this cycle
//   terminal out  count has reached LIMIT-1
// ---------------------------------------------------------------------------
module seq_watchdog #(
    parameter int LIMIT = 4096
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic terminal
);

    localparam int W = (LIMIT > 2) ? $clog2(LIMIT) : 1;
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] count;

    assign terminal = (count == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (en && !terminal) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/read_sequencer.sv
// ---------------------------------------------------------------------------
// read_sequencer
// Control FSM that runs one read_module job: optional kernel load, then
// NUM_IMAGES image requests, each closed by IMAGE_PIXELS pixel beats, then an
// interrupt held until the PS acknowledges it.
// Optional feature macro: SEQ_TIMEOUT_EN (stalled-stream watchdog + ERROR).
//
// Ports:
//   clk          in   clock, rising edge
//   reset        in   asynchronous, active-low; clears all state and outputs
//   start        in   job request (level), sampled in IDLE only
//   skip_kernel  in   sampled with start; 1 skips the kernel load
//   ack          in   interrupt acknowledge (DONE / ERROR only)
//   pixel_valid  in   pixel strobe from read_module
//   read_kernel  out  kernel load request
//   read_image   out  one-cycle image start pulse
//   interrupt    out  job done or error, held until ack
//   busy         out  high in every state except IDLE
//   image_idx    out  current image index
//   pixel_cnt    out  pixels received in the current image
//   timeout_err  out  watchdog fired (0 when the watchdog is not built)
//   dbg_state    out  current FSM state, for observation only
//
// Handshake: pixel_valid is a one-way strobe with no ready. Every cycle it
// is high while the FSM is in IMAGE_STREAM is one accepted beat; in any
// other state it is dropped without effect.
// ---------------------------------------------------------------------------
module read_sequencer
    import read_seq_pkg::*;
#(
    parameter int KERNEL_SIZE    = DEF_KERNEL_SIZE,
    parameter int KERNEL_LATENCY = DEF_KERNEL_LATENCY,
    parameter int NUM_IMAGES     = DEF_NUM_IMAGES,
    parameter int IMAGE_PIXELS   = DEF_IMAGE_PIXELS,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    localparam int IDX_W = (NUM_IMAGES > 1) ? $clog2(NUM_IMAGES) : 1,
    localparam int CNT_W = $clog2(IMAGE_PIXELS + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             skip_kernel,
    input  logic             ack,
    input  logic             pixel_valid,
    output logic             read_kernel,
    output logic             read_image,
    output logic             interrupt,
    output logic             busy,
    output logic [IDX_W-1:0] image_idx,
    output logic [CNT_W-1:0] pixel_cnt,
    output logic             timeout_err,
    output seq_state_t       dbg_state
);

    localparam int KWIN = KERNEL_SIZE + KERNEL_LATENCY;
    localparam int KW   = (KWIN > 2) ? $clog2(KWIN) : 1;

    // The down-counter is loaded with window-1 so LOAD_KERNEL lasts exactly
    // KWIN cycles (it leaves on the cycle the count reads zero).
    localparam logic [KW-1:0]    KLOAD    = KW'(KWIN - 1);
    localparam logic [CNT_W-1:0] PIX_MAX  = CNT_W'(IMAGE_PIXELS);
    localparam logic [CNT_W-1:0] PIX_LAST = CNT_W'(IMAGE_PIXELS - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_IMAGES - 1);

    // Elaboration-time sanity check of the configuration.
    if (KWIN < 1 || NUM_IMAGES < 1 || IMAGE_PIXELS < 1 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("read_sequencer: illegal parameter set");
    end

    seq_state_t       state, state_nxt;
    logic [KW-1:0]    kcnt, kcnt_nxt;
    logic [IDX_W-1:0] idx_nxt;
    logic [CNT_W-1:0] pcnt_nxt;

    assign dbg_state = state;

`ifdef SEQ_TIMEOUT_EN
    logic wd_terminal;

    // Restart on stream entry (from IMAGE_REQ) and on every accepted beat,
    // so the watchdog measures idle cycles since the last sign of life.
    seq_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .reset    (reset),
        .load     ((state == IMAGE_REQ) || ((state == IMAGE_STREAM) && pixel_valid)),
        .en       (state == IMAGE_STREAM),
        .terminal (wd_terminal)
    );
`else
    assign timeout_err = 1'b0;
`endif

    // Next-state and next-value logic.
    always_comb begin
        state_nxt = state;
        kcnt_nxt  = kcnt;
        idx_nxt   = image_idx;
        pcnt_nxt  = pixel_cnt;

        case (state)
            IDLE: begin
                if (start) begin
                    idx_nxt = '0;
                    if (skip_kernel) begin
                        state_nxt = IMAGE_REQ;
                    end else begin
                        state_nxt = LOAD_KERNEL;
                        kcnt_nxt  = KLOAD;
                    end
                end
            end
            LOAD_KERNEL: begin
                if (kcnt == '0) begin
                    state_nxt = IMAGE_REQ;
                end else begin
                    kcnt_nxt = kcnt - 1'b1;
                end
            end
            IMAGE_REQ: begin
                state_nxt = IMAGE_STREAM;
            end
            IMAGE_STREAM: begin
                if (pixel_valid) begin
                    if (pixel_cnt != PIX_MAX) begin
                        pcnt_nxt = pixel_cnt + 1'b1;
                    end
                    if (pixel_cnt == PIX_LAST) begin
                        if (image_idx == IDX_LAST) begin
                            state_nxt = DONE;
                        end else begin
                            idx_nxt   = image_idx + 1'b1;
                            state_nxt = IMAGE_REQ;
                        end
                    end
                end
`ifdef SEQ_TIMEOUT_EN
                else if (wd_terminal) begin
                    state_nxt = ERROR;
                end
`endif
            end
            DONE: begin
                // ack takes priority over start: the FSM lands in IDLE and
                // only looks at start from the next cycle on.
                if (ack) begin
                    state_nxt = IDLE;
                end
            end
`ifdef SEQ_TIMEOUT_EN
            ERROR: begin
                if (ack) begin
                    state_nxt = IDLE;
                end
            end
`endif
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // The pixel count reads zero in the same cycle as the read_image pulse.
        if (state_nxt == IMAGE_REQ) begin
            pcnt_nxt = '0;
        end
    end

    // State register plus registered outputs decoded from the next state,
    // so every output changes on the same edge as the state it reflects.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            kcnt        <= '0;
            image_idx   <= '0;
            pixel_cnt   <= '0;
            read_kernel <= 1'b0;
            read_image  <= 1'b0;
            interrupt   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            kcnt        <= kcnt_nxt;
            image_idx   <= idx_nxt;
            pixel_cnt   <= pcnt_nxt;
            read_kernel <= (state_nxt == LOAD_KERNEL);
            read_image  <= (state_nxt == IMAGE_REQ);
            busy        <= (state_nxt != IDLE);
`ifdef SEQ_TIMEOUT_EN
            interrupt   <= (state_nxt == DONE) || (state_nxt == ERROR);
`else
            interrupt   <= (state_nxt == DONE);
`endif
        end
    end

`ifdef SEQ_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= (state_nxt == ERROR);
        end
    end
`endif

endmodule

// File: tb/tb_read_sequencer.sv
// ---------------------------------------------------------------------------
// tb_read_sequencer
// Directed bench for read_sequencer with KERNEL_SIZE=9, KERNEL_LATENCY=2,
// NUM_IMAGES=3, IMAGE_PIXELS=16, TIMEOUT_CYCLES=32. Inputs are driven and
// outputs sampled 1 ns after each rising edge.
// ---------------------------------------------------------------------------
module tb_read_sequencer;
    import read_seq_pkg::*;

    localparam int KS = 9;
    localparam int KL = 2;
    localparam int NI = 3;
    localparam int IP = 16;
    localparam int TO = 32;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic       start       = 1'b0;
    logic       skip_kernel = 1'b0;
    logic       ack         = 1'b0;
    logic       pixel_valid = 1'b0;
    logic       read_kernel;
    logic       read_image;
    logic       interrupt;
    logic       busy;
    logic [1:0] image_idx;
    logic [4:0] pixel_cnt;
    logic       timeout_err;
    seq_state_t dbg_state;

    int vectors     = 0;
    int miscompares = 0;
    int rk_cycles;
    int pmax;
    logic saw_rk;

    // expected image index of each upcoming read_image pulse
    logic [1:0] exp_q[$];

    read_sequencer #(
        .KERNEL_SIZE    (KS),
        .KERNEL_LATENCY (KL),
        .NUM_IMAGES     (NI),
        .IMAGE_PIXELS   (IP),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .skip_kernel (skip_kernel),
        .ack         (ack),
        .pixel_valid (pixel_valid),
        .read_kernel (read_kernel),
        .read_image  (read_image),
        .interrupt   (interrupt),
        .busy        (busy),
        .image_idx   (image_idx),
        .pixel_cnt   (pixel_cnt),
        .timeout_err (timeout_err),
        .dbg_state   (dbg_state)
    );

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        if (read_kernel) saw_rk = 1'b1;
    endtask

    task automatic beats(input int n);
        for (int i = 0; i < n; i++) begin
            pixel_valid = 1'b1;
            tick();
        end
        pixel_valid = 1'b0;
    endtask

    // From an observed IMAGE_REQ cycle: enter the stream and deliver a full image.
    task automatic stream_image();
        pixel_valid = 1'b0;
        tick();
        beats(IP);
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic expect_pulse(input string tag);
        logic [1:0] e;
        chk({tag, "_read_image"}, read_image, 1);
        if (exp_q.size() == 0) begin
            chk({tag, "_queue_empty"}, 1, 0);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_image_idx"}, image_idx, e);
        end
    endtask

    // Wait (bounded) for the read_image pulse, counting read_kernel cycles.
    task automatic wait_kernel_window();
        rk_cycles = read_kernel ? 1 : 0;
        pmax = 0;
        for (int i = 0; i < 30 && !read_image; i++) begin
            tick();
            if (read_kernel) rk_cycles++;
            if (int'(pixel_cnt) > pmax) pmax = int'(pixel_cnt);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "bench time limit reached");
    end

    // ---------------- directed sequence ----------------
    initial begin
        saw_rk = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_read_kernel", read_kernel, 0);
        chk("rst_read_image",  read_image,  0);
        chk("rst_interrupt",   interrupt,   0);
        chk("rst_busy",        busy,        0);
        chk("rst_image_idx",   image_idx,   0);
        chk("rst_pixel_cnt",   pixel_cnt,   0);
        chk("rst_timeout_err", timeout_err, 0);
        reset = 1'b1;
        tick();
        tick();

        // ---- full job with kernel load ----
        exp_q = '{2'd0, 2'd1, 2'd2};
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("job_busy",        busy,        1);
        chk("job_read_kernel", read_kernel, 1);
        pixel_valid = 1'b1;  // stray strobes during LOAD_KERNEL
        wait_kernel_window();
        pixel_valid = 1'b0;
        chk("job_kernel_len",   rk_cycles, KS + KL);
        chk("job_stray_pixels", pmax,      0);
        expect_pulse("job_img0");
        chk("job_img0_kernel_off", read_kernel, 0);
        tick();
        chk("job_stream_cnt0", pixel_cnt, 0);
        beats(7);
        chk("job_cnt7", pixel_cnt, 7);
        // start and ack while busy mid-stream: both ignored
        start = 1'b1;
        ack   = 1'b1;
        tick();
        start = 1'b0;
        ack   = 1'b0;
        chk("busy_start_cnt",    pixel_cnt,   7);
        chk("busy_start_idx",    image_idx,   0);
        chk("busy_start_rk",     read_kernel, 0);
        chk("busy_start_ri",     read_image,  0);
        chk("busy_ack_int",      interrupt,   0);
        beats(9);
        expect_pulse("job_img1");
        chk("job_img1_cnt", pixel_cnt, 0);
        stream_image();
        expect_pulse("job_img2");
        tick();
        beats(IP - 1);
        chk("job_pre_last_int", interrupt, 0);
        chk("job_pre_last_cnt", pixel_cnt, IP - 1);
        beats(1);
        chk("job_done_int",  interrupt,  1);
        chk("job_done_cnt",  pixel_cnt,  IP);
        chk("job_done_ri",   read_image, 0);
        chk("job_done_busy", busy,       1);
        pixel_valid = 1'b1;  // stray strobe in DONE
        tick();
        pixel_valid = 1'b0;
        tick();
        chk("done_hold_cnt", pixel_cnt, IP);
        chk("done_hold_int", interrupt, 1);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("ack_int",  interrupt, 0);
        chk("ack_busy", busy,      0);

        // ---- skip-kernel job ----
        exp_q = '{2'd0, 2'd1, 2'd2};
        saw_rk = 1'b0;
        start = 1'b1;
        skip_kernel = 1'b1;
        tick();
        start = 1'b0;
        skip_kernel = 1'b0;
        expect_pulse("skip_img0");
        chk("skip_busy", busy, 1);
        stream_image();
        expect_pulse("skip_img1");
        stream_image();
        expect_pulse("skip_img2");
        stream_image();
        chk("skip_done_int", interrupt, 1);
        chk("skip_no_kernel", saw_rk, 0);

        // ---- ack/start collision in DONE ----
        ack = 1'b1;
        start = 1'b1;
        tick();
        ack = 1'b0;
        chk("coll_int",  interrupt,   0);
        chk("coll_busy", busy,        0);
        chk("coll_rk",   read_kernel, 0);
        tick();              // start still high, now sampled in IDLE
        start = 1'b0;
        chk("coll_restart_busy", busy,        1);
        chk("coll_restart_rk",   read_kernel, 1);
        exp_q = '{2'd0, 2'd1};
        wait_kernel_window();
        chk("coll_kernel_len", rk_cycles, KS + KL);
        expect_pulse("coll_img0");
        stream_image();
        expect_pulse("coll_img1");
        tick();
        beats(7);
        chk("pre_rst_cnt", pixel_cnt, 7);
        chk("pre_rst_idx", image_idx, 1);

        // ---- asynchronous reset mid-job ----
        reset = 1'b0;
        #1;
        chk("arst_busy",      busy,        0);
        chk("arst_pixel_cnt", pixel_cnt,   0);
        chk("arst_image_idx", image_idx,   0);
        chk("arst_read_kernel", read_kernel, 0);
        chk("arst_read_image",  read_image,  0);
        chk("arst_interrupt",   interrupt,   0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk("post_rst_busy", busy, 0);
        exp_q = '{2'd0};
        start = 1'b1;
        skip_kernel = 1'b1;
        tick();
        start = 1'b0;
        skip_kernel = 1'b0;
        expect_pulse("post_rst_img0");
        tick();              // now in IMAGE_STREAM, stalled from here

`ifdef SEQ_TIMEOUT_EN
        // ---- watchdog ----
        repeat (TO - 1) tick();
        chk("wd_pre_terminal_err", timeout_err, 0);
        chk("wd_pre_terminal_busy", busy, 1);
        pixel_valid = 1'b1;  // beat on the terminal cycle restarts the count
        tick();
        pixel_valid = 1'b0;
        chk("wd_restart_cnt", pixel_cnt,   1);
        chk("wd_restart_err", timeout_err, 0);
        chk("wd_restart_int", interrupt,   0);
        repeat (TO - 1) tick();
        chk("wd_before_fire_err", timeout_err, 0);
        tick();
        chk("wd_fire_err", timeout_err, 1);
        chk("wd_fire_int", interrupt,   1);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("wd_ack_err",  timeout_err, 0);
        chk("wd_ack_int",  interrupt,   0);
        chk("wd_ack_busy", busy,        0);
`else
        // ---- stalled stream waits indefinitely ----
        repeat (TO + 8) tick();
        chk("stall_err",  timeout_err, 0);
        chk("stall_busy", busy,        1);
        chk("stall_int",  interrupt,   0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
